// File: rtl/auto_parkcalc_div_pkg.sv
// Shared types and constants for the auto_parkcalc sequential signed divider.
// Width constants mirror the 32s x 34ns -> 65 product path this divider inverts.
package auto_parkcalc_div_pkg;

  localparam int DIVIDEND_W = 65;
  localparam int DIVISOR_W  = 34;
  localparam int QUOT_W     = 32;

  localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/auto_parkcalc_sdiv_65s_34ns_32_seq_if.sv
// Request/result bundle of the sequential signed divider.
// The master drives operands and handshake; the slave returns the result and flags.
interface auto_parkcalc_sdiv_65s_34ns_32_seq_if
  import auto_parkcalc_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOT_WIDTH     = QUOT_W
);

  logic                      ce;
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] din0;
  logic [DIVISOR_WIDTH-1:0]  din1;
  logic                      ready;
  logic                      done;
  logic [QUOT_WIDTH-1:0]     quot;
  logic [DIVISOR_WIDTH:0]    rem;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, quot, rem, div_by_zero, overflow
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, quot, rem, div_by_zero, overflow
  );

endinterface

// File: rtl/auto_parkcalc_sdiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module auto_parkcalc_sdiv_step
  import auto_parkcalc_div_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DIVISOR_W
) (
  input  logic [DIVISOR_WIDTH:0]   prem_in,
  input  logic                     dvd_bit,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   prem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH+1:0] shifted;
  logic [DIVISOR_WIDTH+1:0] diff;

  // prem_in < divisor keeps shifted below 2^(W+1), so the top bit of diff is the borrow.
  always_comb begin
    shifted  = {prem_in, dvd_bit};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[DIVISOR_WIDTH+1];
    prem_out = q_bit ? diff[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
  end

endmodule

// File: rtl/auto_parkcalc_sdiv_65s_34ns_32_seq.sv
// Iterative signed divider: 65-bit signed dividend by 34-bit unsigned divisor,
// saturating 32-bit signed quotient and exact remainder, one quotient bit per enabled cycle.
module auto_parkcalc_sdiv_65s_34ns_32_seq
  import auto_parkcalc_div_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOT_WIDTH     = QUOT_W
) (
  input logic clk,
  input logic reset_n,
  auto_parkcalc_sdiv_65s_34ns_32_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
  localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = DIVIDEND_WIDTH'(QUOT_MAX);
  localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = DIVIDEND_WIDTH'(QUOT_MIN);

  // ID only tags the instance in the netlist.
  if (ID < 0) begin : g_id_tag
  end

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH:0]   dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic                      neg_q, neg_d;
  logic                      zdiv_q, zdiv_d;
  logic [DIVISOR_WIDTH:0]    prem_q, prem_d;
  logic [DIVIDEND_WIDTH-1:0] qmag_q, qmag_d;
  logic [QUOT_WIDTH-1:0]     quot_q, quot_d;
  logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
  logic                      dbz_q, dbz_d;
  logic                      ovf_q, ovf_d;

  logic [DIVIDEND_WIDTH:0]   din_ext;
  logic                      dvd_bit;
  logic [DIVISOR_WIDTH:0]    step_prem;
  logic                      step_qbit;

  assign dvd_bit = dvd_q[cnt_q];

  auto_parkcalc_sdiv_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .prem_in  (prem_q),
    .dvd_bit  (dvd_bit),
    .divisor  (divisor_q),
    .prem_out (step_prem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    neg_d     = neg_q;
    zdiv_d    = zdiv_q;
    prem_d    = prem_q;
    qmag_d    = qmag_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    din_ext   = {bus.din0[DIVIDEND_WIDTH-1], bus.din0};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisor_d = bus.din1;
          if (bus.din1 == '0) begin
            zdiv_d  = 1'b1;
            state_d = FIX;
          end else begin
            // One extra bit so that |-2^64| is representable.
            zdiv_d  = 1'b0;
            neg_d   = bus.din0[DIVIDEND_WIDTH-1];
            dvd_d   = neg_d ? (~din_ext + 1'b1) : din_ext;
            prem_d  = '0;
            qmag_d  = '0;
            cnt_d   = CNT_W'(DIVIDEND_WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_prem;
        qmag_d = {qmag_q[DIVIDEND_WIDTH-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = DONE;
        if (zdiv_q) begin
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          dbz_d = 1'b0;
          rem_d = neg_q ? -prem_q : prem_q;
          // A negative quotient may reach one step further than a positive one.
          if (!neg_q && (qmag_q > POS_LIMIT)) begin
            quot_d = QUOT_MAX;
            ovf_d  = 1'b1;
          end else if (neg_q && (qmag_q > NEG_LIMIT)) begin
            quot_d = QUOT_MIN;
            ovf_d  = 1'b1;
          end else begin
            quot_d = neg_q ? -qmag_q[QUOT_WIDTH-1:0] : qmag_q[QUOT_WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      zdiv_q    <= 1'b0;
      prem_q    <= '0;
      qmag_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (bus.ce) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      neg_q     <= neg_d;
      zdiv_q    <= zdiv_d;
      prem_q    <= prem_d;
      qmag_q    <= qmag_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
